// File: rtl/rom_instr_sequencer.sv
// Instruction fetch/decode sequencer: walks a synchronous program ROM and presents
// decoded ALU/register-file control fields, one instruction at a time.
module rom_instr_sequencer #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              stop,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  input  logic              alu_busy,
  output logic [15:0]       alu_op,
  output logic [3:0]        alu_addr_3,
  output logic [3:0]        alu_addr_2,
  output logic [3:0]        alu_addr_1,
  output logic [15:0]       reg_write_data,
  output logic              issue_valid,
  output logic              running,
  output logic              halted,
  output logic              err,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       instr_count
);

  typedef enum logic [2:0] {IDLE, F1, D1, D2, ISSUE, HALTED} state_t;
  typedef enum logic [2:0] {CLS_ALU, CLS_LDI, CLS_RD, CLS_HALT, CLS_ILLEGAL} iclass_t;

  typedef struct packed {
    logic [15:0] op;
    logic [3:0]  addr_3;
    logic [3:0]  addr_2;
    logic [3:0]  addr_1;
    logic [15:0] wdata;
  } fields_t;

  localparam logic [7:0] OPC_ADD  = 8'h00;
  localparam logic [7:0] OPC_SUB  = 8'h01;
  localparam logic [7:0] OPC_AND  = 8'h02;
  localparam logic [7:0] OPC_OR   = 8'h03;
  localparam logic [7:0] OPC_XOR  = 8'h04;
  localparam logic [7:0] OPC_LDI  = 8'h11;
  localparam logic [7:0] OPC_RD   = 8'h12;
  localparam logic [7:0] OPC_HALT = 8'hFF;

  function automatic iclass_t classify(input logic [7:0] opc);
    case (opc)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_XOR: classify = CLS_ALU;
      OPC_LDI:  classify = CLS_LDI;
      OPC_RD:   classify = CLS_RD;
      OPC_HALT: classify = CLS_HALT;
      default:  classify = CLS_ILLEGAL;
    endcase
  endfunction

  // Source registers only exist for ALU ops, the immediate only for LDI.
  function automatic fields_t decode(input logic [15:0] operator_w,
                                     input logic [15:0] operand_w);
    iclass_t cls;
    cls           = classify(operator_w[15:8]);
    decode        = '0;
    decode.op     = operator_w;
    decode.addr_3 = operator_w[3:0];
    if (cls == CLS_ALU) begin
      decode.addr_2 = operand_w[11:8];
      decode.addr_1 = operand_w[3:0];
    end
    if (cls == CLS_LDI) decode.wdata = operand_w;
  endfunction

  state_t      state;
  fields_t     fields_q;
  logic [15:0] operator_q;
  iclass_t     rom_class;
  logic        two_word;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    rom_en    = 1'b0;
    rom_class = classify(rom_data[15:8]);
    two_word  = (rom_class == CLS_ALU) || (rom_class == CLS_LDI);
    if (!stop) begin
      case (state)
        F1:      rom_en = 1'b1;
        D1:      rom_en = two_word;
        default: rom_en = 1'b0;
      endcase
    end
  end

  assign rom_addr       = pc;
  assign issue_valid    = (state == ISSUE) && !alu_busy && !stop;
  assign running        = (state != IDLE) && (state != HALTED);
  assign halted         = (state == HALTED);
  assign alu_op         = fields_q.op;
  assign alu_addr_3     = fields_q.addr_3;
  assign alu_addr_2     = fields_q.addr_2;
  assign alu_addr_1     = fields_q.addr_1;
  assign reg_write_data = fields_q.wdata;

  // NOTE: sequential state uses non-blocking <= so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= '0;
      err         <= 1'b0;
      instr_count <= '0;
      operator_q  <= '0;
      fields_q    <= '0;
    end else if (stop) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE, HALTED: begin
          if (start) begin
            state       <= F1;
            pc          <= start_addr;
            err         <= 1'b0;
            instr_count <= '0;
          end
        end
        F1: begin
          pc    <= pc + 1'b1;
          state <= D1;
        end
        D1: begin
          operator_q <= rom_data;
          case (rom_class)
            CLS_ALU, CLS_LDI: begin
              pc    <= pc + 1'b1;
              state <= D2;
            end
            CLS_RD: begin
              fields_q <= decode(rom_data, 16'h0000);
              state    <= ISSUE;
            end
            CLS_HALT: state <= HALTED;
            default: begin
              err   <= 1'b1;
              state <= F1;
            end
          endcase
        end
        D2: begin
          fields_q <= decode(operator_q, rom_data);
          state    <= ISSUE;
        end
        ISSUE: begin
          if (!alu_busy) begin
            instr_count <= instr_count + 16'd1;
            state       <= F1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_instr_sequencer.sv
// Scoreboard bench for rom_instr_sequencer: an instruction-level model predicts
// issue timing/fields, fetch addresses and final state; a negedge monitor compares.
module tb_rom_instr_sequencer;
  localparam int ADDR_W = 8;
  localparam int BUSY_N = 512;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic              stop;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic              alu_busy;
  logic [15:0]       alu_op;
  logic [3:0]        alu_addr_3;
  logic [3:0]        alu_addr_2;
  logic [3:0]        alu_addr_1;
  logic [15:0]       reg_write_data;
  logic              issue_valid;
  logic              running;
  logic              halted;
  logic              err;
  logic [ADDR_W-1:0] pc;
  logic [15:0]       instr_count;

  rom_instr_sequencer #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .stop(stop),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data), .alu_busy(alu_busy),
    .alu_op(alu_op), .alu_addr_3(alu_addr_3), .alu_addr_2(alu_addr_2),
    .alu_addr_1(alu_addr_1), .reg_write_data(reg_write_data),
    .issue_valid(issue_valid), .running(running), .halted(halted), .err(err),
    .pc(pc), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Synchronous program ROM with one cycle of read latency.
  logic [15:0] rom_mem [256];
  logic [15:0] rom_q = 16'h0000;
  logic        rom_ovr = 1'b1;
  assign rom_data = rom_ovr ? 16'hFFFF : rom_q;
  always @(posedge clk) if (rom_en) rom_q <= rom_mem[rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cycle;
    logic [15:0] op;
    logic [3:0]  a3;
    logic [3:0]  a2;
    logic [3:0]  a1;
    logic [15:0] wdata;
    logic [7:0]  pc;
  } issue_t;

  issue_t     exp_q[$];
  logic [7:0] fetch_q[$];
  bit         busy_at [BUSY_N];
  int         vectors = 0;
  int         miscompares = 0;
  int         base = 0;
  int         cur_c = 0;
  bit         fetch_chk = 1'b0;
  int         exp_halt_cycle;
  logic [7:0]  exp_pc;
  logic        exp_err;
  logic [15:0] exp_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every issue pops one prediction; every ROM read pops one address.
  issue_t mon_e;
  logic [7:0] mon_a;
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (issue_valid) begin
        if (exp_q.size() == 0) check("spurious_issue", issue_valid, 0);
        else begin
          mon_e = exp_q.pop_front();
          check("issue_cycle", cyc - base, mon_e.cycle);
          check("issue_alu_op", alu_op, mon_e.op);
          check("issue_addr_3", alu_addr_3, mon_e.a3);
          check("issue_addr_2", alu_addr_2, mon_e.a2);
          check("issue_addr_1", alu_addr_1, mon_e.a1);
          check("issue_wdata", reg_write_data, mon_e.wdata);
          check("issue_pc", pc, mon_e.pc);
        end
      end
      if (fetch_chk && rom_en) begin
        if (fetch_q.size() == 0) check("spurious_fetch", rom_en, 0);
        else begin
          mon_a = fetch_q.pop_front();
          check("fetch_addr", rom_addr, mon_a);
        end
      end
    end
  end

  // Instruction-level reference: cycle 0 is the first cycle after the start edge.
  task automatic predict(input logic [7:0] sa);
    logic [7:0]  a;
    logic [15:0] w;
    logic [15:0] opd;
    logic [7:0]  opc;
    int          t;
    int          s;
    issue_t      e;
    a = sa; t = 0;
    exp_q.delete(); fetch_q.delete();
    exp_err = 1'b0; exp_count = 16'd0; exp_halt_cycle = -1;
    for (int n = 0; n < 64; n++) begin
      w = rom_mem[a]; fetch_q.push_back(a); a++;
      opc = w[15:8];
      if (opc <= 8'h04 || opc == 8'h11) begin
        opd = rom_mem[a]; fetch_q.push_back(a); a++;
        s = t + 3;
        while (s < BUSY_N - 1 && busy_at[s]) s++;
        e.cycle = s; e.op = w; e.a3 = w[3:0];
        e.a2    = (opc <= 8'h04) ? opd[11:8] : 4'h0;
        e.a1    = (opc <= 8'h04) ? opd[3:0] : 4'h0;
        e.wdata = (opc == 8'h11) ? opd : 16'h0000;
        e.pc    = a;
        exp_q.push_back(e); exp_count++; t = s + 1;
      end else if (opc == 8'h12) begin
        s = t + 2;
        while (s < BUSY_N - 1 && busy_at[s]) s++;
        e.cycle = s; e.op = w; e.a3 = w[3:0]; e.a2 = 4'h0; e.a1 = 4'h0;
        e.wdata = 16'h0000; e.pc = a;
        exp_q.push_back(e); exp_count++; t = s + 1;
      end else if (opc == 8'hFF) begin
        exp_halt_cycle = t + 2;
        break;
      end else begin
        exp_err = 1'b1; t = t + 2;
      end
    end
    exp_pc = a;
  endtask

  task automatic begin_run(input logic [7:0] sa);
    @(negedge clk);
    start = 1'b1; start_addr = sa; base = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0; cur_c = 0; alu_busy = busy_at[0];
  endtask

  task automatic step_to(input int c);
    while (cur_c < c) begin
      @(posedge clk); #1;
      cur_c++;
      alu_busy = (cur_c < BUSY_N) ? busy_at[cur_c] : 1'b0;
    end
  endtask

  task automatic run_program(input logic [7:0] sa, input bit glitch);
    predict(sa);
    fetch_chk = 1'b1;
    begin_run(sa);
    if (glitch && exp_halt_cycle > 7) begin
      step_to(5); start = 1'b1; start_addr = sa + 8'h80;
      step_to(6); start = 1'b0;
    end
    step_to(exp_halt_cycle - 1);
    check("running_before_halt", running, 1);
    check("halted_early", halted, 0);
    step_to(exp_halt_cycle);
    check("halted", halted, 1);
    check("running_after_halt", running, 0);
    check("final_pc", pc, exp_pc);
    check("final_err", err, exp_err);
    check("final_count", instr_count, exp_count);
    check("issues_outstanding", exp_q.size(), 0);
    check("fetches_outstanding", fetch_q.size(), 0);
    fetch_chk = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rom_en"}, rom_en, 0);
    check({tag, "_rom_addr"}, rom_addr, 0);
    check({tag, "_alu_op"}, alu_op, 0);
    check({tag, "_addr_3"}, alu_addr_3, 0);
    check({tag, "_addr_2"}, alu_addr_2, 0);
    check({tag, "_addr_1"}, alu_addr_1, 0);
    check({tag, "_wdata"}, reg_write_data, 0);
    check({tag, "_issue_valid"}, issue_valid, 0);
    check({tag, "_running"}, running, 0);
    check({tag, "_halted"}, halted, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_pc"}, pc, 0);
    check({tag, "_count"}, instr_count, 0);
  endtask

  task automatic clear_env(input logic [15:0] fill);
    for (int i = 0; i < 256; i++) rom_mem[i] = fill;
    for (int i = 0; i < BUSY_N; i++) busy_at[i] = 1'b0;
    exp_q.delete(); fetch_q.delete();
  endtask

  task automatic load_plan_program();
    rom_mem[0] = 16'h1101; rom_mem[1] = 16'h0004;
    rom_mem[2] = 16'h1102; rom_mem[3] = 16'h0004;
    rom_mem[4] = 16'h0103; rom_mem[5] = 16'h0201;
    rom_mem[6] = 16'h1203; rom_mem[7] = 16'hFF00;
  endtask

  task automatic build_random(output logic [7:0] sa);
    logic [7:0] a;
    logic [7:0] opc;
    int         r;
    int         n;
    for (int i = 0; i < 256; i++) rom_mem[i] = 16'($urandom_range(0, 65535));
    for (int i = 0; i < BUSY_N; i++) busy_at[i] = ($urandom_range(0, 3) == 0);
    sa = 8'($urandom_range(0, 255));
    a  = sa;
    n  = $urandom_range(2, 9);
    for (int k = 0; k < n; k++) begin
      r = $urandom_range(0, 9);
      if (r <= 4 || r == 9) opc = (r == 9) ? 8'h00 : 8'(r);
      else if (r <= 6) opc = 8'h11;
      else if (r == 7) opc = 8'h12;
      else begin
        opc = 8'($urandom_range(5, 254));
        while (opc == 8'h11 || opc == 8'h12) opc = 8'($urandom_range(5, 254));
      end
      rom_mem[a] = {opc, 8'($urandom_range(0, 255))}; a++;
      if (opc <= 8'h04 || opc == 8'h11) begin
        rom_mem[a] = 16'($urandom_range(0, 65535)); a++;
      end
    end
    rom_mem[a] = {8'hFF, 8'($urandom_range(0, 255))};
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] sa;
    reset = 1'b0; start = 1'b0; stop = 1'b0; alu_busy = 1'b0; start_addr = '0;
    clear_env(16'hFF00);

    // Reset with the ROM bus floating high.
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1; rom_ovr = 1'b0;
    @(negedge clk);
    check("post_reset_running", running, 0);
    check("post_reset_halted", halted, 0);

    // Reference program, with an ignored start pulse while running.
    load_plan_program();
    run_program(8'h00, 1'b1);

    // Same program, three busy cycles during the SUB issue.
    busy_at[11] = 1'b1; busy_at[12] = 1'b1; busy_at[13] = 1'b1;
    run_program(8'h00, 1'b0);

    // Illegal opcode followed by RD.
    clear_env(16'hFF00);
    rom_mem[8'h10] = 16'h7A00; rom_mem[8'h11] = 16'h1205;
    run_program(8'h10, 1'b0);

    // Two-word instruction straddling the address wrap.
    clear_env(16'hFF00);
    rom_mem[8'hFF] = 16'h0003; rom_mem[8'h00] = 16'h0201;
    run_program(8'hFF, 1'b0);

    // Stop during D2 of an LDI: pc, err and count retained, no issue.
    clear_env(16'hFF00);
    rom_mem[8'h40] = 16'h7A00; rom_mem[8'h41] = 16'h1203;
    rom_mem[8'h42] = 16'h1105; rom_mem[8'h43] = 16'h1234;
    predict(8'h40);
    fetch_chk = 1'b1;
    begin_run(8'h40);
    step_to(7); stop = 1'b1;
    step_to(8); stop = 1'b0;
    fetch_chk = 1'b0;
    check("stop_d2_running", running, 0);
    check("stop_d2_halted", halted, 0);
    check("stop_d2_pc", pc, 8'h44);
    check("stop_d2_err", err, 1);
    check("stop_d2_count", instr_count, 1);
    step_to(12);
    check("stop_d2_idle", running, 0);
    check("stop_d2_pending", exp_q.size(), 1);
    exp_q.delete(); fetch_q.delete();

    // Stop in ISSUE with busy low: the issue is suppressed.
    rom_mem[8'h50] = 16'h1201;
    begin_run(8'h50);
    step_to(2); stop = 1'b1;
    step_to(3); stop = 1'b0;
    check("stop_issue_count", instr_count, 0);
    check("stop_issue_pc", pc, 8'h51);
    check("stop_issue_running", running, 0);

    // Start together with stop: stop wins.
    @(negedge clk); start = 1'b1; stop = 1'b1; start_addr = 8'h99;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    @(negedge clk);
    check("start_stop_running", running, 0);
    check("start_stop_pc", pc, 8'h51);

    // Asynchronous reset while stalled in ISSUE.
    clear_env(16'hFF00);
    rom_mem[8'h60] = 16'h1207; rom_mem[8'h61] = 16'h7A00;
    rom_mem[8'h62] = 16'h1101; rom_mem[8'h63] = 16'h0004;
    for (int i = 8; i <= 40; i++) busy_at[i] = 1'b1;
    predict(8'h60);
    fetch_chk = 1'b1;
    begin_run(8'h60);
    step_to(9);
    check("stall_alu_op", alu_op, 16'h1101);
    check("stall_wdata", reg_write_data, 16'h0004);
    check("stall_issue_valid", issue_valid, 0);
    check("stall_err", err, 1);
    check("stall_count", instr_count, 1);
    fetch_chk = 1'b0;
    #2 reset = 1'b0;
    #1 check_all_zero("async_reset");
    alu_busy = 1'b0;
    @(negedge clk); reset = 1'b1;
    exp_q.delete(); fetch_q.delete();

    // Randomized programs with random stalls.
    for (int k = 0; k < 40; k++) begin
      build_random(sa);
      run_program(sa, 1'($urandom_range(0, 1)));
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rom_instr_sequencer.md
# rom_instr_sequencer

Instruction fetch/decode sequencer sitting directly upstream of `alu_register_verilog`. It reads operator/operand words from a synchronous program ROM and decodes them into the ALU/register-file control fields: `op`, `alu_addr_1/2/3` and `reg_write_data`. It issues one instruction at a time, stalls on `alu_busy`, and stops at HALT. It replaces the hand-driven stimulus currently used to exercise the ALU/register stage.

## Interface
- `ADDR_W`, default 8: ROM address width. PC wraps modulo 2^ADDR_W.
- `clk`, in, 1: clock. All state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: single-cycle pulse. Begins execution at `start_addr`.
- `start_addr`, in, ADDR_W: first ROM address to fetch.
- `stop`, in, 1: synchronous abort to IDLE.
- `rom_en`, out, 1: ROM read enable.
- `rom_addr`, out, ADDR_W: ROM read address.
- `rom_data`, in, 16: ROM read data, valid 1 cycle after the `rom_en` edge.
- `alu_busy`, in, 1: downstream stall.
- `alu_op`, out, 16: full operator word; drives `op`.
- `alu_addr_3`, out, 4: destination register, = operator[3:0].
- `alu_addr_2`, out, 4: source 2, = operand[11:8] for ALU ops, else 0.
- `alu_addr_1`, out, 4: source 1, = operand[3:0] for ALU ops, else 0.
- `reg_write_data`, out, 16: immediate, = operand for LDI, else 0.
- `issue_valid`, out, 1: the decoded fields are being consumed this cycle.
- `running`, out, 1: high when the FSM is not in IDLE or HALTED.
- `halted`, out, 1: high in HALTED.
- `err`, out, 1: sticky illegal-opcode flag.
- `pc`, out, ADDR_W: next fetch address.
- `instr_count`, out, 16: count of issued instructions.

## Operation
- Opcode is operator[15:8].
- Two-word instructions:
  - ALU ops: 0x00 ADD, 0x01 SUB, 0x02 AND, 0x03 OR, 0x04 XOR.
  - 0x11 LDI.
- One-word instructions:
  - 0x12 RD.
  - 0xFF HALT.
  - Any other opcode is illegal: one word, not issued, sets `err`, execution continues.
- FSM states: IDLE, F1, D1, D2, ISSUE, HALTED.
- IDLE / HALTED, on `start`:
  - `pc` <= `start_addr`; `err` <= 0; `instr_count` <= 0; next state F1.
- F1:
  - `rom_en` = 1, `rom_addr` = `pc`; `pc` <= `pc` + 1; next state D1.
- D1: capture `rom_data` as the operator, then branch on opcode:
  - two-word: `rom_en` = 1, `rom_addr` = `pc`, `pc` <= `pc` + 1, next state D2;
  - RD: next state ISSUE;
  - HALT: next state HALTED;
  - illegal: set `err`, next state F1.
- D2:
  - capture `rom_data` as the operand; next state ISSUE.
- Output fields (`alu_op`, `alu_addr_*`, `reg_write_data`):
  - registered; loaded on entry to ISSUE;
  - held stable until the next ISSUE entry or reset.
- ISSUE:
  - `issue_valid` = !`alu_busy` (combinational).
  - If `alu_busy` = 0: `instr_count` += 1 (wraps at 0xFFFF); next state F1.
  - If `alu_busy` = 1: remain in ISSUE with all fields held.
- `stop` from any state:
  - next state IDLE; no issue that cycle; `pc`, `err` and `instr_count` retain their values.
- `stop` and `start` in the same cycle: `stop` wins.
- `start` is ignored while `running`.
- Reset (asynchronous, mid-operation included), all outputs and state forced to 0:
  - state IDLE;
  - `pc`, all fields, `issue_valid`, `rom_en`, `err`, `instr_count`, `running`, `halted` = 0.

## Timing
- Two-word instruction: F1, D1, D2, ISSUE = 4 cycles minimum.
- RD: F1, D1, ISSUE = 3 cycles.
- HALT: F1, D1 = 2 cycles, then `halted` is high.
- Illegal opcode: 2 cycles, then the next F1.
- ROM latency is fixed at 1 cycle; `rom_data` is sampled only in D1 and D2.
- A two-word instruction at address 2^ADDR_W − 1 fetches its operand from address 0.
- `alu_busy` stalls add exactly one cycle each. No instruction is dropped or duplicated.

## Test plan
- Reset: drive `reset` = 0 while `rom_data` = 0xFFFF → every output = 0; state IDLE after release.
- Program at address 0: 0x1101/0x0004, 0x1102/0x0004, 0x0103/0x0201, 0x1203, 0xFF00, with `start_addr` = 0. Required response:
  - four `issue_valid` pulses, 4, 4, 4 and 3 cycles apart;
  - LDI issues: `alu_op` = 0x1101 then 0x1102, with `reg_write_data` = 4;
  - SUB issue: `alu_op` = 0x0103, `alu_addr_3` = 3, `alu_addr_2` = 2, `alu_addr_1` = 1;
  - `halted` = 1 and `instr_count` = 4 at the end.
- `alu_busy` = 1 for 3 cycles during the SUB ISSUE → fields held, a single `issue_valid` pulse, total latency 7 cycles.
- Word 0x7A00 followed by 0x1205 → `err` = 1, no issue for 0x7A00; RD issued next with `alu_op` = 0x1205.
- `ADDR_W` = 8, `start_addr` = 0xFF, ROM[0xFF] = 0x0003, ROM[0x00] = 0x0201 → `rom_addr` sequence 0xFF, 0x00; ADD issued; `pc` = 0x01.
- Timed aborts:
  - `stop` asserted in D2 → IDLE, no issue, `pc` retained;
  - `reset` pulsed low between clock edges during ISSUE → outputs 0 immediately.
